mult_booth_seq: RTL and testbench
=================================

Name: mult_booth_seq

Overview:
- Multicycle signed multiplier in the ALU datapath, directly downstream of the carry-lookahead adder.
- Implements radix-2 Booth: one add/subtract of the multiplicand per cycle, fed through a WIDTH+1-bit CLA-style add path with carry-in used for two's-complement subtract.
- Produces a WIDTH-bit product, an overflow exception and a one-cycle ready pulse for the processor's multdiv stall logic.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be a multiple of 8, matching the 8-bit CLA slice granularity.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- ctrl_mult  input  1  start pulse; operands are sampled on the same edge.
- data_a  input  WIDTH  multiplicand, signed.
- data_b  input  WIDTH  multiplier, signed.
- data_result  output  WIDTH  low WIDTH bits of the signed product. Registered.
- data_exception  output  1  product does not fit in WIDTH signed bits. Registered.
- data_resultRDY  output  1  one-cycle pulse when data_result and data_exception are valid.
- busy  output  1  high while an operation is in progress.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE.
  - All internal registers are cleared.
  - data_result = 0, data_exception = 0, data_resultRDY = 0, busy = 0.
  - Reset asserted mid-operation aborts the operation; no RDY pulse follows.
- Internal registers:
  - M: WIDTH+1 bits, data_a sign-extended.
  - ACC: WIDTH+1 bits.
  - Q: WIDTH bits.
  - q_m1: 1 bit.
  - cnt: CNT_W bits.
- States:
  - IDLE:
    - On ctrl_mult=1: load M = sext(data_a), ACC = 0, Q = data_b, q_m1 = 0, cnt = 0; go to RUN.
    - busy rises the cycle after ctrl_mult.
  - RUN, one Booth step per cycle. Examine {Q[0], q_m1}:
    - 01: ACC + M.
    - 10: ACC + ~M with carry-in 1.
    - 00 or 11: ACC + 0.
    - Then arithmetic right shift of {sum, Q, q_m1} by 1, replicating the MSB of sum.
    - cnt increments each step.
    - After step WIDTH (cnt == WIDTH-1 during that step), go to DONE.
  - DONE, held for one cycle:
    - data_result = Q, i.e. product[WIDTH-1:0].
    - data_exception = 1 unless product[2*WIDTH-1:WIDTH-1] is all-zeros or all-ones. The product is {ACC[WIDTH-1:0], Q}.
    - data_resultRDY = 1 and busy = 0 are asserted together with the outputs.
    - Next state: IDLE.
- Latency:
  - ctrl_mult sampled at edge 0.
  - data_resultRDY is high in the cycle following edge WIDTH+1, i.e. 33 cycles for WIDTH=32.
- Output hold: data_result and data_exception hold their values until the next DONE or reset. data_resultRDY is 0 in every other cycle.
- ctrl_mult while RUN:
  - The operation restarts; new operands are loaded and cnt is cleared.
  - No RDY pulse is issued for the aborted operation.
- ctrl_mult in the DONE cycle:
  - Accepted: the result is still presented and RDY pulses.
  - The new operation starts in RUN on the next cycle.
- Width rule: ACC is WIDTH+1 bits so that subtracting M = -2^(WIDTH-1) cannot overflow the accumulator. The carry out of the adder is discarded.
- Zero operands still take the full WIDTH steps; there is no early termination.

Test Plan:
- Basic product: reset, then ctrl_mult with a=3, b=5.
  - data_resultRDY pulses exactly once, 33 cycles after the start.
  - data_result = 0x0000000F, data_exception = 0, busy low in the RDY cycle.
- Signed operands: a=-7 (0xFFFFFFF9), b=6.
  - data_result = 0xFFFFFFD6, data_exception = 0.
  - Repeat with a=6, b=-7 for the same result.
- Overflow cases:
  - a=0x80000000, b=0xFFFFFFFF: data_result = 0x80000000, data_exception = 1.
  - a=0x00010000, b=0x00010000: data_result = 0, data_exception = 1.
  - a=0x80000000, b=1: data_result = 0x80000000, data_exception = 0.
- Restart: start 3*5, then at cycle 10 pulse ctrl_mult with a=4, b=4.
  - Exactly one RDY pulse, 33 cycles after the second start.
  - data_result = 0x10.
- Reset mid-op: start 9*9, deassert reset_n at cycle 15 for 2 cycles.
  - All outputs read 0 immediately, asynchronously.
  - No RDY pulse follows.
  - A subsequent 9*9 returns 0x51.
- Back-to-back: assert ctrl_mult (a=2, b=-3) in the DONE cycle of a 5*5 operation.
  - First result 25 with its RDY pulse.
  - Second RDY 33 cycles later with 0xFFFFFFFA.

Source files
------------

// File: rtl/mult_booth_seq_if.sv
// Handshake/data bundle between the multdiv control logic and the Booth multiplier.
interface mult_booth_seq_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_mult;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  // Requester side: issues operands, consumes the result.
  modport master (
    output ctrl_mult, data_a, data_b,
    input  data_result, data_exception, data_resultRDY, busy
  );

  // Multiplier side.
  modport slave (
    input  ctrl_mult, data_a, data_b,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/mult_booth_seq.sv
// Radix-2 Booth sequential signed multiplier. One add/sub per cycle through a
// WIDTH+1-bit two-level carry-lookahead adder built from 8-bit slices.

// One lookahead slice: local sum from an external carry-in, plus group
// generate/propagate that do not depend on that carry-in (no comb loop).
module mult_booth_seq_cla_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a_i,
  input  logic [SW-1:0] b_i,
  input  logic          ci_i,
  output logic [SW-1:0] s_o,
  output logic          g_o,
  output logic          p_o
);
  logic [SW-1:0] g, p, c;
  logic          gg;

  // Bit carries inside the slice and group generate/propagate.
  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c    = '0;
    c[0] = ci_i;
    for (int i = 0; i < SW - 1; i++) c[i+1] = g[i] | (p[i] & c[i]);
    gg = 1'b0;
    for (int i = 0; i < SW; i++) gg = g[i] | (p[i] & gg);
    s_o = p ^ c;
    g_o = gg;
    p_o = &p;
  end
endmodule

module mult_booth_seq #(
  parameter int WIDTH = 32,  // multiple of 8
  parameter int CNT_W = 6    // 2**CNT_W > WIDTH
) (
  input  logic                 clock,
  input  logic                 reset_n,
  mult_booth_seq_if.slave      bus
);
  localparam int SW  = 8;
  localparam int NSL = WIDTH / SW;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;

  // Adder datapath.
  logic [WIDTH:0]   op;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [NSL-1:0]   sl_g, sl_p;
  logic [NSL:0]     sl_c;
  logic [WIDTH:0]   hi;
  logic             ovf;

  // Booth recode: 01 adds M, 10 adds ~M with carry-in (subtract), else add 0.
  always_comb begin
    op  = '0;
    cin = 1'b0;
    unique case ({q_q[0], qm1_q})
      2'b01:   op = m_q;
      2'b10: begin
        op  = ~m_q;
        cin = 1'b1;
      end
      default: op = '0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NSL; gi++) begin : g_slice
      mult_booth_seq_cla_slice #(.SW(SW)) u_slice (
        .a_i  (acc_q[gi*SW +: SW]),
        .b_i  (op[gi*SW +: SW]),
        .ci_i (sl_c[gi]),
        .s_o  (sum[gi*SW +: SW]),
        .g_o  (sl_g[gi]),
        .p_o  (sl_p[gi])
      );
    end
  endgenerate

  // Slice-level lookahead carries; the extra sign bit is a single full-adder
  // stage and its carry out is dropped.
  always_comb begin
    sl_c    = '0;
    sl_c[0] = cin;
    for (int i = 0; i < NSL; i++) sl_c[i+1] = sl_g[i] | (sl_p[i] & sl_c[i]);
    sum[WIDTH] = acc_q[WIDTH] ^ op[WIDTH] ^ sl_c[NSL];
  end

  // Product fits in WIDTH signed bits only if product[2W-1:W-1] is all-equal.
  always_comb begin
    hi  = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    ovf = ~((&hi) | ~(|hi));
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    exc_d   = exc_q;
    rdy_d   = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: ;
      RUN: begin
        // Arithmetic shift of {sum, Q, q_m1} right by one.
        acc_d = {sum[WIDTH], sum[WIDTH:1]};
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        res_d   = q_q;
        exc_d   = ovf;
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A start in any state (re)loads operands; a start during RUN aborts the
    // old operation silently, a start in DONE still lets its result out.
    if (bus.ctrl_mult) begin
      m_d     = {bus.data_a[WIDTH-1], bus.data_a};
      acc_d   = '0;
      q_d     = bus.data_b;
      qm1_d   = 1'b0;
      cnt_d   = '0;
      busy_d  = 1'b1;
      state_d = RUN;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.data_result    = res_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;
endmodule

// File: tb/tb_mult_booth_seq.sv
// Directed bench for mult_booth_seq: products, overflow, restart, reset, back-to-back.
module tb_mult_booth_seq;
  logic clock = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  mult_booth_seq_if #(.WIDTH(32)) bus ();

  mult_booth_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Caller sits at a negedge; the start is sampled on the next posedge.
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    bus.ctrl_mult = 1'b1;
    bus.data_a    = a;
    bus.data_b    = b;
    @(negedge clock);
    bus.ctrl_mult = 1'b0;
  endtask

  // Watch ncyc negedges; report first RDY index, pulse count and captured outputs.
  task automatic watch(input int ncyc, output int first, output int pulses,
                       output logic [31:0] r, output logic e, output logic bsy);
    first = -1; pulses = 0; r = '0; e = 1'b0; bsy = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clock);
      if (bus.data_resultRDY) begin
        pulses++;
        if (first < 0) begin
          first = k; r = bus.data_result; e = bus.data_exception; bsy = bus.busy;
        end
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ee);
    int f, p; logic [31:0] r; logic e, bsy;
    start(a, b);
    watch(40, f, p, r, e, bsy);
    chk({tag, "_lat"}, 64'(f), 64'd33);
    chk({tag, "_pulses"}, 64'(p), 64'd1);
    chk({tag, "_res"}, 64'(r), 64'(er));
    chk({tag, "_exc"}, 64'(e), 64'(ee));
  endtask

  initial begin
    int f, p; logic [31:0] r; logic e, bsy;
    reset_n = 1'b0;
    bus.ctrl_mult = 1'b0; bus.data_a = '0; bus.data_b = '0;
    repeat (2) @(negedge clock);
    chk("rst_res", 64'(bus.data_result), 64'd0);
    chk("rst_exc", 64'(bus.data_exception), 64'd0);
    chk("rst_rdy", 64'(bus.data_resultRDY), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Basic 3*5 with busy checks.
    start(32'd3, 32'd5);
    chk("basic_busy_rise", 64'(bus.busy), 64'd1);
    watch(40, f, p, r, e, bsy);
    chk("basic_lat", 64'(f), 64'd33);
    chk("basic_pulses", 64'(p), 64'd1);
    chk("basic_res", 64'(r), 64'h0000000F);
    chk("basic_exc", 64'(e), 64'd0);
    chk("basic_busy_rdy", 64'(bsy), 64'd0);

    run_op("neg_a", 32'hFFFFFFF9, 32'd6, 32'hFFFFFFD6, 1'b0);
    run_op("neg_b", 32'd6, 32'hFFFFFFF9, 32'hFFFFFFD6, 1'b0);
    run_op("ovf_min_m1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    run_op("ovf_2p32", 32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
    run_op("min_x1", 32'h80000000, 32'd1, 32'h80000000, 1'b0);
    run_op("zero", 32'd0, 32'h12345678, 32'h00000000, 1'b0);
    run_op("min_min", 32'h80000000, 32'h80000000, 32'h00000000, 1'b1);

    // Restart at cycle 10 of a 3*5.
    start(32'd3, 32'd5);
    p = 0;
    for (int k = 1; k < 10; k++) begin
      @(negedge clock);
      if (bus.data_resultRDY) p++;
    end
    chk("restart_early_rdy", 64'(p), 64'd0);
    start(32'd4, 32'd4);
    watch(45, f, p, r, e, bsy);
    chk("restart_lat", 64'(f), 64'd33);
    chk("restart_pulses", 64'(p), 64'd1);
    chk("restart_res", 64'(r), 64'h10);

    // Asynchronous reset mid-operation.
    start(32'd9, 32'd9);
    repeat (15) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("amid_res", 64'(bus.data_result), 64'd0);
    chk("amid_exc", 64'(bus.data_exception), 64'd0);
    chk("amid_rdy", 64'(bus.data_resultRDY), 64'd0);
    chk("amid_busy", 64'(bus.busy), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    watch(40, f, p, r, e, bsy);
    chk("amid_no_rdy", 64'(p), 64'd0);
    run_op("after_rst", 32'd9, 32'd9, 32'h51, 1'b0);

    // Back-to-back: new start in the DONE cycle of 5*5.
    start(32'd5, 32'd5);
    p = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clock);
      if (bus.data_resultRDY) p++;
    end
    chk("b2b_early_rdy", 64'(p), 64'd0);
    start(32'd2, 32'hFFFFFFFD);
    chk("b2b_rdy1", 64'(bus.data_resultRDY), 64'd1);
    chk("b2b_res1", 64'(bus.data_result), 64'd25);
    chk("b2b_exc1", 64'(bus.data_exception), 64'd0);
    watch(40, f, p, r, e, bsy);
    chk("b2b_lat2", 64'(f), 64'd33);
    chk("b2b_pulses2", 64'(p), 64'd1);
    chk("b2b_res2", 64'(r), 64'hFFFFFFFA);
    chk("b2b_exc2", 64'(e), 64'd0);
    chk("b2b_hold", 64'(bus.data_result), 64'hFFFFFFFA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
